// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with a 40-bit frame.
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   dht_in     data line as seen on the wire (asynchronous, wired-AND with host)
//   dht_oe     1 = pull the line low, 0 = release it to the pull-up
//   hum_int    humidity integer byte
//   hum_dec    humidity decimal byte
//   temp_int   temperature integer byte
//   temp_dec   temperature decimal byte
//   busy       high from an accepted start until the end of the frame
//   frame_done one-cycle pulse when the 50us tail completes
module dht11_responder #(
    parameter int CLKS_PER_US  = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
);
    localparam int MX0 = START_MIN_US > RESP_WAIT_US ? START_MIN_US : RESP_WAIT_US;
    localparam int MX  = MX0 > 80 ? MX0 : 80;
    localparam int CW  = $clog2(MX + 1);
    localparam int PW  = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre;
    logic [1:0]    sync;
    logic [CW-1:0] us_cnt, dur;
    logic [39:0]   frame;
    logic [5:0]    bit_idx;
    logic          tick, line, done;

    assign tick = pre == PW'(CLKS_PER_US - 1);
    assign line = sync[1];

    // Duration of the current timed state; a state ends on the tick that
    // completes its last microsecond.
    always_comb begin
        dur = state == RESP_WAIT ? CW'(RESP_WAIT_US) :
              (state == RESP_LOW || state == RESP_HIGH) ? CW'(80) :
              (state == BIT_LOW || state == END_LOW) ? CW'(50) :
              frame[bit_idx] ? CW'(70) : CW'(26);
        done = tick && us_cnt == dur - 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!line) state_nx = HOST_LOW;
            HOST_LOW:  if (line) state_nx = us_cnt >= CW'(START_MIN_US) ? RESP_WAIT : IDLE;
            RESP_WAIT: if (done) state_nx = RESP_LOW;
            RESP_LOW:  if (done) state_nx = RESP_HIGH;
            RESP_HIGH: if (done) state_nx = BIT_LOW;
            BIT_LOW:   if (done) state_nx = BIT_HIGH;
            BIT_HIGH:  if (done) state_nx = bit_idx == 6'd0 ? END_LOW : BIT_LOW;
            END_LOW:   if (done) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    assign dht_oe = state == RESP_LOW || state == BIT_LOW || state == END_LOW;
    assign busy   = state != IDLE && state != HOST_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre        <= '0;
            sync       <= 2'b11;
            us_cnt     <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            pre   <= tick ? '0 : pre + 1'b1;
            sync  <= {sync[0], dht_in};
            // Saturating counter keeps a very long host-low from wrapping back below the threshold.
            if (state_nx != state)
                us_cnt <= '0;
            else if (tick && us_cnt != '1)
                us_cnt <= us_cnt + 1'b1;
            // Snapshot at acceptance so byte changes mid-frame cannot corrupt the frame.
            if (state == HOST_LOW && state_nx == RESP_WAIT)
                frame <= {hum_int, hum_dec, temp_int, temp_dec, hum_int + hum_dec + temp_int + temp_dec};
            if (state == RESP_HIGH && state_nx == BIT_LOW)
                bit_idx <= 6'd39;
            else if (state == BIT_HIGH && state_nx == BIT_LOW)
                bit_idx <= bit_idx - 1'b1;
            frame_done <= state == END_LOW && state_nx == IDLE;
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: self-checking bench for dht11_responder measuring the line waveform.
module tb_dht11_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hi = 8'h0, hd = 8'h0, ti = 8'h0, td = 8'h0;
    logic       dht_in, dht_oe, busy, frame_done;
    int         pass_n = 0, total_n = 0, fd_cnt = 0;

    assign dht_in = ~(host_low | dht_oe);

    dht11_responder #(.CLKS_PER_US(1), .START_MIN_US(18), .RESP_WAIT_US(30)) dut (
        .clk(clk), .rst_n(rst_n), .dht_in(dht_in), .dht_oe(dht_oe),
        .hum_int(hi), .hum_dec(hd), .temp_int(ti), .temp_dec(td),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    typedef struct {
        logic [7:0]  a, b, c, d;
        int          host_us;
        bit          acc;
        logic [39:0] exp;
        string       tag;
    } vec_t;

    function automatic logic [39:0] model(input logic [7:0] a, b, c, d);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        return {a, b, c, d, 8'(s)};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic measure(input logic lvl, output int len);
        len = 0;
        while (dht_oe === lvl && len < 400) begin
            @(negedge clk);
            len++;
        end
    endtask

    // action: 0 none, 1 change hum_int during bit 20, 2 host pulse during bits, 3 reset during RESP_LOW
    task automatic run_frame(input logic [7:0] a, b, c, d, input int host_us, input bit acc,
                             input logic [39:0] exp, input int action, input string tag);
        logic [39:0] got;
        int len, dly, bad_low, bad_high, fd0, seen_oe, seen_busy;
        got = '0; bad_low = 0; bad_high = 0;
        hi = a; hd = b; ti = c; td = d;
        @(negedge clk);
        fd0 = fd_cnt;
        host_low = 1'b1;
        repeat (host_us) @(negedge clk);
        host_low = 1'b0;
        if (!acc) begin
            seen_oe = 0; seen_busy = 0;
            repeat (150) begin
                @(negedge clk);
                seen_oe |= int'(dht_oe);
                seen_busy |= int'(busy);
            end
            check({tag, " oe_quiet"}, seen_oe, 0);
            check({tag, " busy_quiet"}, seen_busy, 0);
            check({tag, " no_done"}, fd_cnt - fd0, 0);
            return;
        end
        dly = 0;
        while (!dht_oe && dly < 200) begin
            @(negedge clk);
            dly++;
        end
        check({tag, " resp_delay_ok"}, int'(dly >= 30 && dly <= 36), 1);
        check({tag, " busy"}, busy, 1);
        if (action == 3) begin
            repeat (20) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check({tag, " oe_in_reset"}, dht_oe, 0);
            check({tag, " busy_in_reset"}, busy, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            check({tag, " idle_after_reset"}, {busy, dht_oe}, 0);
            return;
        end
        measure(1'b1, len);
        check({tag, " pre_low"}, len, 80);
        measure(1'b0, len);
        check({tag, " pre_high"}, len, 80);
        for (int i = 0; i < 40; i++) begin
            measure(1'b1, len);
            if (len != 50) bad_low++;
            if (action == 1 && i == 20) hi = 8'h50;
            if (action == 2 && i == 10)
                fork
                    begin
                        repeat (30) @(negedge clk);
                        host_low = 1'b1;
                        repeat (25) @(negedge clk);
                        host_low = 1'b0;
                    end
                join_none
            measure(1'b0, len);
            got = {got[38:0], len > 48};
            if (len != (exp[39-i] ? 70 : 26)) bad_high++;
        end
        check({tag, " bit_low_errs"}, bad_low, 0);
        check({tag, " bit_high_errs"}, bad_high, 0);
        check({tag, " frame"}, got, exp);
        measure(1'b1, len);
        check({tag, " tail"}, len, 50);
        check({tag, " done_pulse"}, frame_done, 1);
        check({tag, " busy_end"}, busy, 0);
        repeat (20) @(negedge clk);
        check({tag, " done_once"}, fd_cnt - fd0, 1);
        check({tag, " idle_quiet"}, {busy, dht_oe}, 0);
    endtask

    vec_t v[6];

    initial begin
        logic [7:0] r[8];
        for (int i = 0; i < 8; i++) r[i] = 8'($urandom);
        v[0] = '{8'h37, 8'h00, 8'h19, 8'h05, 20, 1'b1, 40'h0, "basic"};
        v[1] = '{8'h37, 8'h00, 8'h19, 8'h05, 10, 1'b0, 40'h0, "glitch10"};
        v[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 20, 1'b1, 40'h0, "all_ff"};
        v[3] = '{r[0], r[1], r[2], r[3], 16, 1'b0, 40'h0, "reject16"};
        v[4] = '{r[0], r[1], r[2], r[3], 22, 1'b1, 40'h0, "accept22"};
        v[5] = '{r[4], r[5], r[6], r[7], 30, 1'b1, 40'h0, "random"};
        foreach (v[i]) if (v[i].acc) v[i].exp = model(v[i].a, v[i].b, v[i].c, v[i].d);

        repeat (3) @(negedge clk);
        check("reset oe", dht_oe, 0);
        check("reset busy", busy, 0);
        check("reset done", frame_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("model csum basic", v[0].exp[7:0], 8'h55);
        check("model csum ff", v[2].exp[7:0], 8'hFC);
        foreach (v[i]) run_frame(v[i].a, v[i].b, v[i].c, v[i].d, v[i].host_us, v[i].acc, v[i].exp, 0, v[i].tag);

        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 20, 1'b1, model(8'h37, 8'h00, 8'h19, 8'h05), 1, "byte_change");
        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 20, 1'b1, model(8'h37, 8'h00, 8'h19, 8'h05), 3, "reset_mid");
        run_frame(8'h12, 8'h34, 8'h56, 8'h78, 20, 1'b1, model(8'h12, 8'h34, 8'h56, 8'h78), 0, "after_reset");
        run_frame(8'hA5, 8'h5A, 8'h0F, 8'hF0, 20, 1'b1, model(8'hA5, 8'h5A, 8'h0F, 8'hF0), 2, "host_pulse");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
